led_pattern_seq: RTL and testbench
==================================

# led_pattern_seq

Parametrised LED pattern sequencer for the board LED bank. It runs a fixed show in three phases: blink the whole bank, shift an alternating pattern out, then fill or drain symmetrically from the centre. It is clocked from the system clock and paced by an internal tick strobe, with no derived clocks. Width, blink length and step rate are generic, and a compile-time option selects looping or one-shot operation.

## Interface
- WIDTH, 16, number of LEDs; must be even and ≥ 4
- BLINK_TOGGLES, 12, number of inversions in BLINK before SHIFT starts
- DIV_BITS, 25, step period is 2^DIV_BITS clk cycles
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- en  input  1  step enable; low freezes the sequence
- dir  input  1  direction; sampled only on a step
- led  output  WIDTH  LED drive (bit WIDTH-1 is the leftmost LED)
- phase  output  2  current phase: 0 BLINK, 1 SHIFT, 2 FILL, 3 DONE
- step  output  1  one-clk pulse on each applied step

## Operation
- Tick strobe: a DIV_BITS-bit counter free-runs regardless of en. tick=1 for the single cycle when the counter equals 2^DIV_BITS−1, after which it wraps to 0.
- Step = tick & en. All sequence state changes only on a step.
- State held: phase, blink_cnt (sized for 0..BLINK_TOGGLES), a 3·WIDTH-bit shift register sreg (led shows its middle WIDTH bits during SHIFT), and fill_lvl (0..WIDTH/2).
- Reset values: led all-ones, phase 0, step 0, blink_cnt 0, sreg 0, fill_lvl 0, divider 0.
- BLINK:
  - If blink_cnt == BLINK_TOGGLES: load sreg so the window holds alternating 1010… (MSB=1), drive led from it, go to SHIFT.
  - Otherwise: led ← ~led and blink_cnt++.
- SHIFT:
  - If window == 0: fill_lvl ← 1, led ← centre mask(1), go to FILL.
  - Otherwise: dir=1 shifts sreg left by 1, dir=0 shifts it right by 1, zero fill. Bits that leave the window are kept in sreg, so reversing direction brings them back until they fall off the 3·WIDTH ends.
- FILL: centre mask(k) means bits WIDTH/2−k … WIDTH/2+k−1 are set.
  - fill_lvl == WIDTH/2 (all on): exit as described under Configuration.
  - dir=0: fill_lvl++ (expand outward).
  - dir=1: fill_lvl−1, saturating at 0; at 0 the bank stays all-off.
  - led ← centre mask(fill_lvl) after each update.
- DONE: led held all-ones; steps are ignored.
- step output = registered copy of (tick & en) for phases 0–2. It is 0 in DONE.

## Timing
- All registers update on the rising clk edge; rst clears everything immediately, including mid-phase and the divider.
- First step occurs at the edge 2^DIV_BITS cycles after rst deasserts. Steps then repeat every 2^DIV_BITS cycles while en=1.
- led, phase and step change on the edge at which the tick is seen. There are no extra pipeline stages.
- The boundary checks (blink_cnt limit, window zero, full fill) use pre-step values. Each terminal pattern is therefore displayed for exactly one step before the transition.
- en deasserted on a tick cycle means that step is lost; it is not deferred.

## Configuration
- LED_SEQ_LOOP_EN defined: when FILL is full, the next step sets led ← all-zeros, blink_cnt ← 0, phase ← BLINK, and the show repeats indefinitely.
- LED_SEQ_LOOP_EN undefined: when FILL is full, the next step goes to DONE with led all-ones, held until rst.

## Structure
- Package led_seq_pkg contains:
  - the phase enum typedef (BLINK/SHIFT/FILL/DONE);
  - default parameter constants;
  - function centre_mask(width, level);
  - function alt_pattern(width).
- Sub-module tick_strobe (parameter DIV_BITS; ports clk, rst, tick) implements the divider.

## Test plan
Bench setup: WIDTH=8, BLINK_TOGGLES=4, DIV_BITS=2 (a step every 4 clk), en=1.
- Reset, then run 5 steps → led FF, 00, FF, 00, FF, then AA on step 5 with phase=1.
- From AA, dir=1 → led 54, A8, 50, A0, 40, 80, 00; the next step gives 18 with phase=2.
- From AA: 2 steps with dir=1 (A8), then 2 steps with dir=0 → 54 then AA (bits recovered).
- From 18, dir=0 → 3C, 7E, FF, then the next step:
  - without LOOP_EN: phase=3, led FF, and led stays FF for 10 further steps;
  - with LOOP_EN: led 00, phase=0.
- From 3C, dir=1 → 18, 00, 00; then dir=0 → 18.
- en=0 for 20 cycles mid-SHIFT → led, phase, step frozen. rst pulse mid-SHIFT → led FF, phase 0 within the same cycle.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types, default parameters and pattern helpers for the LED pattern sequencer.
// The helpers return MAX_WIDTH-bit vectors; callers size-cast the result down to their WIDTH.
package led_seq_pkg;

    typedef enum logic [1:0] {
        PH_BLINK = 2'd0,
        PH_SHIFT = 2'd1,
        PH_FILL  = 2'd2,
        PH_DONE  = 2'd3
    } phase_e;

    localparam int DEF_WIDTH         = 16;
    localparam int DEF_BLINK_TOGGLES = 12;
    localparam int DEF_DIV_BITS      = 25;
    localparam int MAX_WIDTH         = 64;

    // Bits width/2-level .. width/2+level-1 set; level 0 gives an all-off bank.
    function automatic logic [MAX_WIDTH-1:0] centre_mask(input int width, input int level);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if ((i >= (width / 2) - level) && (i < (width / 2) + level)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // 1010... across the low width bits, MSB set (width is even, so odd bits are ones).
    function automatic logic [MAX_WIDTH-1:0] alt_pattern(input int width);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if ((i < width) && ((i % 2) == 1)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/led_pattern_seq_tick_strobe.sv
// Free-running step-rate divider: one-cycle tick each time the counter reaches all-ones.
module tick_strobe
    import led_seq_pkg::*;
#(
    parameter int DIV_BITS = DEF_DIV_BITS
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [DIV_BITS-1:0] cnt_q;
    logic [DIV_BITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/led_pattern_seq.sv
// Board LED show: blink the bank, shift an alternating pattern out, then fill/drain from the centre.
// Define LED_SEQ_LOOP_EN to restart the show after a full fill instead of stopping in DONE.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// PH_BLINK | invert the whole bank once per step, BLINK_TOGGLES times
// PH_SHIFT | shift the alternating pattern through a 3*WIDTH register (dir)
// PH_FILL  | grow (dir=0) or shrink (dir=1) a lit band around the centre
// PH_DONE  | bank held all-on, steps ignored until rst
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int BLINK_TOGGLES = DEF_BLINK_TOGGLES,
    parameter int DIV_BITS      = DEF_DIV_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] led,
    output logic [1:0]       phase,
    output logic             step
);

    localparam int CNT_W  = $clog2(BLINK_TOGGLES + 2);
    localparam int LVL_W  = $clog2(WIDTH / 2 + 1);
    localparam int SREG_W = 3 * WIDTH;

    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TOGGLES);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(WIDTH / 2);
    localparam logic [WIDTH-1:0] ALT        = WIDTH'(alt_pattern(WIDTH));

    logic tick;
    logic step_in;

    phase_e              phase_q, phase_d;
    logic [WIDTH-1:0]    led_q, led_d;
    logic                step_q, step_d;
    logic [CNT_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic [SREG_W-1:0]   sreg_q, sreg_d;
    logic [LVL_W-1:0]    fill_lvl_q, fill_lvl_d;

    tick_strobe #(
        .DIV_BITS (DIV_BITS)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign step_in = tick & en;

    always_comb begin
        phase_d     = phase_q;
        led_d       = led_q;
        step_d      = 1'b0;
        blink_cnt_d = blink_cnt_q;
        sreg_d      = sreg_q;
        fill_lvl_d  = fill_lvl_q;

        if (step_in) begin
            case (phase_q)
                PH_BLINK: begin
                    step_d = 1'b1;
                    if (blink_cnt_q == BLINK_LAST) begin
                        sreg_d                    = '0;
                        sreg_d[2*WIDTH-1:WIDTH]   = ALT;
                        led_d                     = ALT;
                        phase_d                   = PH_SHIFT;
                    end else begin
                        led_d       = ~led_q;
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end

                PH_SHIFT: begin
                    step_d = 1'b1;
                    if (sreg_q[2*WIDTH-1:WIDTH] == '0) begin
                        fill_lvl_d = LVL_W'(1);
                        led_d      = WIDTH'(centre_mask(WIDTH, 1));
                        phase_d    = PH_FILL;
                    end else begin
                        // Bits leaving the window stay in the outer thirds so a reversal recovers them.
                        if (dir) begin
                            sreg_d = {sreg_q[SREG_W-2:0], 1'b0};
                        end else begin
                            sreg_d = {1'b0, sreg_q[SREG_W-1:1]};
                        end
                        led_d = sreg_d[2*WIDTH-1:WIDTH];
                    end
                end

                PH_FILL: begin
                    step_d = 1'b1;
                    if (fill_lvl_q == LVL_FULL) begin
`ifdef LED_SEQ_LOOP_EN
                        led_d       = '0;
                        blink_cnt_d = '0;
                        phase_d     = PH_BLINK;
`else
                        led_d   = '1;
                        phase_d = PH_DONE;
`endif
                    end else begin
                        if (!dir) begin
                            fill_lvl_d = fill_lvl_q + 1'b1;
                        end else if (fill_lvl_q != '0) begin
                            fill_lvl_d = fill_lvl_q - 1'b1;
                        end
                        led_d = WIDTH'(centre_mask(WIDTH, int'(fill_lvl_d)));
                    end
                end

                PH_DONE: begin
                    led_d = '1;
                end

                default: begin
                    phase_d = PH_BLINK;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= PH_BLINK;
            led_q       <= '1;
            step_q      <= 1'b0;
            blink_cnt_q <= '0;
            sreg_q      <= '0;
            fill_lvl_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            led_q       <= led_d;
            step_q      <= step_d;
            blink_cnt_q <= blink_cnt_d;
            sreg_q      <= sreg_d;
            fill_lvl_q  <= fill_lvl_d;
        end
    end

    assign led   = led_q;
    assign phase = phase_q;
    assign step  = step_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with WIDTH=8, BLINK_TOGGLES=4, DIV_BITS=2 (a step every 4 clk).
module tb_led_pattern_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       dir;
    logic [7:0] led;
    logic [1:0] phase;
    logic       step;

    int n_checks = 0;
    int n_pass   = 0;

    led_pattern_seq #(
        .WIDTH         (8),
        .BLINK_TOGGLES (4),
        .DIV_BITS      (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .dir   (dir),
        .led   (led),
        .phase (phase),
        .step  (step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    // Advance n step periods; returns #1 after the edge that applied the last step.
    task automatic step_n(input int n);
        repeat (n) begin
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] exp_led, input logic [1:0] exp_ph);
        chk({tag, "_led"}, led, exp_led);
        chk({tag, "_phase"}, 8'(phase), 8'(exp_ph));
    endtask

    logic [7:0] blink_exp [4];
    logic [7:0] shl_exp   [6];

    initial begin
        blink_exp = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        shl_exp   = '{8'hA8, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};

        rst = 1'b1;
        en  = 1'b1;
        dir = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 8'hFF, 2'd0);
        chk("reset_step", 8'(step), 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            step_n(1);
            chk_state("blink", blink_exp[i], 2'd0);
            chk("blink_step", 8'(step), 8'h01);
        end
        step_n(1);
        chk_state("to_shift", 8'hAA, 2'd1);

        dir = 1'b1;
        @(posedge clk);
        #1;
        chk("step_pulse_low", 8'(step), 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk_state("shl0", 8'h54, 2'd1);
        chk("shl0_step", 8'(step), 8'h01);
        for (int i = 0; i < 6; i++) begin
            step_n(1);
            chk_state("shl", shl_exp[i], 2'd1);
        end
        step_n(1);
        chk_state("to_fill", 8'h18, 2'd2);

        dir = 1'b0;
        step_n(1);
        chk_state("fill_up", 8'h3C, 2'd2);
        dir = 1'b1;
        step_n(1);
        chk_state("drain1", 8'h18, 2'd2);
        step_n(1);
        chk_state("drain0", 8'h00, 2'd2);
        step_n(1);
        chk_state("drain_sat", 8'h00, 2'd2);
        dir = 1'b0;
        step_n(1);
        chk_state("refill1", 8'h18, 2'd2);
        step_n(1);
        chk_state("refill2", 8'h3C, 2'd2);
        step_n(1);
        chk_state("refill3", 8'h7E, 2'd2);
        step_n(1);
        chk_state("full", 8'hFF, 2'd2);

        step_n(1);
`ifdef LED_SEQ_LOOP_EN
        chk_state("loop", 8'h00, 2'd0);
        step_n(1);
        chk_state("loop_blink", 8'hFF, 2'd0);
`else
        chk_state("done", 8'hFF, 2'd3);
        for (int i = 0; i < 10; i++) begin
            step_n(1);
            chk_state("done_hold", 8'hFF, 2'd3);
            chk("done_step", 8'(step), 8'h00);
        end
`endif

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dir = 1'b0;
        step_n(5);
        chk_state("b_shift", 8'hAA, 2'd1);
        dir = 1'b1;
        step_n(1);
        chk_state("b_shl1", 8'h54, 2'd1);
        step_n(1);
        chk_state("b_shl2", 8'hA8, 2'd1);
        dir = 1'b0;
        step_n(1);
        chk_state("b_shr1", 8'h54, 2'd1);
        step_n(1);
        chk_state("b_recover", 8'hAA, 2'd1);

        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("frz_led", led, 8'hAA);
            chk("frz_step", 8'(step), 8'h00);
        end
        chk("frz_phase", 8'(phase), 8'h01);
        en = 1'b1;
        step_n(1);
        chk_state("b_shr2", 8'h55, 2'd1);
        chk("b_shr2_step", 8'(step), 8'h01);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_state("async_rst", 8'hFF, 2'd0);
        chk("async_rst_step", 8'(step), 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
